acc_stream_dma: RTL and testbench
=================================

Name: acc_stream_dma

Overview:
- DMA-side counterpart of the accelerator stream interface.
- Launches one FIR, matmul or sorting job and fetches input words from data memory.
- Drives those words into the accelerator's slave stream, collects result words from the accelerator's master stream, and writes them back to memory.
- Sits between the memory arbiter and the accelerator; configured by the CPU-side register block.

Parameters:
ADDR_W, 32, byte-address width
LEN_W, 8, word-count width
PF_DEPTH, 4, prefetch FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_start  in  1  one-cycle start pulse
cfg_mode  in  3  one-hot job select: 001 fir, 010 matmul, 100 sorting
cfg_src_addr  in  ADDR_W  input buffer byte address, word aligned
cfg_src_len  in  LEN_W  number of input words
cfg_dst_addr  in  ADDR_W  result buffer byte address
cfg_dst_len  in  LEN_W  result buffer capacity in words
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky status of last job; cleared by next accepted cfg_start
rd_req  out  1  memory read request
rd_addr  out  ADDR_W  read address
rd_gnt  in  1  read accepted this cycle
rd_valid  in  1  read data valid; asserted exactly 1 cycle after rd_req&rd_gnt
rd_data  in  32  read data
wr_req  out  1  memory write request
wr_addr  out  ADDR_W  write address
wr_data  out  32  write data
wr_gnt  in  1  write accepted this cycle
acc_ap_start  out  3  job start code to accelerator
acc_ap_idle  in  1  accelerator idle
m_tvalid  out  1  stream to accelerator, valid
m_tdata  out  32  stream to accelerator, data
m_tlast  out  1  stream to accelerator, last
m_tready  in  1  stream to accelerator, ready
s_tvalid  in  1  stream from accelerator, valid
s_tdata  in  32  stream from accelerator, data
s_tlast  in  1  stream from accelerator, last
s_tready  out  1  stream from accelerator, ready

Behaviour:
- Reset values: all outputs 0; FIFO pointers, counters and state cleared; state IDLE.
- IDLE:
  - cfg_start with one-hot cfg_mode and cfg_src_len!=0: latch config, clear err, busy=1, go to LAUNCH.
  - cfg_start with invalid mode or zero length: no launch; done=1 and err=1 on the next cycle.
- LAUNCH:
  - Drive acc_ap_start=mode until acc_ap_idle is sampled 0, then drive 000 and go to STREAM.
  - Read prefetch may begin in LAUNCH.
- STREAM read side:
  - rd_req=1 while issued<src_len and (fifo_count+outstanding)<PF_DEPTH.
  - rd_addr=src_addr+4*issued; issued increments on rd_req&rd_gnt.
  - rd_valid pushes rd_data into the prefetch FIFO.
  - Full FIFO: no request is issued, so no overflow occurs.
- STREAM send side:
  - m_tvalid = FIFO not empty, m_tdata = FIFO head; pop on m_tvalid&m_tready.
  - m_tlast=1 only on word index src_len-1.
  - m_tdata and m_tlast are held stable while m_tvalid&!m_tready.
  - Simultaneous push and pop: count unchanged.
- Receive side (STREAM and DRAIN):
  - One-entry write buffer; s_tready = !wr_req | wr_gnt.
  - On s_tvalid&s_tready with received<dst_len: load wr_data and wr_addr=dst_addr+4*received, assert wr_req, increment received.
  - wr_req, wr_addr and wr_data are held until wr_gnt.
  - received==dst_len: accept and drop the word, set err.
- After the last input word is sent, go to DRAIN.
- DRAIN ends on accepted s_tlast and an empty write buffer -> DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- cfg_start while busy is ignored.
- Address arithmetic is modulo 2^ADDR_W; counters are LEN_W wide with no wrap because len<=2^LEN_W-1.
- Asynchronous rst mid-job returns all state to reset values immediately; partial writes are not rolled back.

Decomposition:
- Shared package acc_dma_pkg:
  - mode codes MODE_FIR/MODE_MATMUL/MODE_SORT.
  - state encoding IDLE/LAUNCH/STREAM/DRAIN/DONE.
- One sub-module: pf_fifo (parameterized synchronous FIFO: push, pop, count, head data).

Test Plan:
- FIR job, mode 001, src_len 64, dst_len 64, m_tready and wr_gnt tied 1, accelerator model echoes data+1:
  - 64 writes to dst_addr..dst_addr+252 with src+1.
  - m_tlast only on word 63; one done pulse; err=0.
- Sorting job, src_len 10 descending 10..1, sort model:
  - 10 writes ascending 1..10.
  - busy falls in the same cycle done pulses.
- Backpressure, m_tready toggling 1-0-0-1 and rd_gnt low every other cycle:
  - no word lost or duplicated.
  - m_tdata stable during stalls.
  - FIFO count never exceeds PF_DEPTH.
- Overflow, matmul src_len 16, dst_len 8, model returns 16 words:
  - exactly 8 writes; remaining 8 accepted (s_tready high) and dropped; err=1.
- Invalid start: cfg_mode 011 or src_len 0 -> no rd_req, acc_ap_start stays 000, done and err on next cycle.
- rst asserted mid-STREAM after 5 words sent:
  - all outputs 0 asynchronously.
  - new cfg_start after release runs a full job correctly.

Source files
------------

// File: rtl/acc_stream_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_dma_pkg
// Purpose  : Shared definitions for the accelerator stream DMA: job mode
//            codes, controller state encoding, and a mode validity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package acc_dma_pkg;

  localparam int DATA_W = 32;

  // One-hot job codes, also forwarded unchanged on acc_ap_start.
  localparam logic [2:0] MODE_FIR    = 3'b001;
  localparam logic [2:0] MODE_MATMUL = 3'b010;
  localparam logic [2:0] MODE_SORT   = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic mode_is_valid(input logic [2:0] mode);
    return (mode == MODE_FIR) || (mode == MODE_MATMUL) || (mode == MODE_SORT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_stream_dma_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_stream_dma_if
// Purpose  : Accelerator-facing bundle of the DMA: job start handshake plus
//            the two data streams (DMA->accelerator and accelerator->DMA).
// Ports    : acc_ap_start/acc_ap_idle  job launch handshake
//            m_t*                      stream into the accelerator
//            s_t*                      stream out of the accelerator
//            modport master = DMA side, modport slave = accelerator side
// Revision : 1.0 - initial release
// ============================================================================
interface acc_stream_dma_if;
  import acc_dma_pkg::*;

  logic [2:0]        acc_ap_start;
  logic              acc_ap_idle;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready;
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              s_tready;

  modport master (
    output acc_ap_start, m_tvalid, m_tdata, m_tlast, s_tready,
    input  acc_ap_idle, m_tready, s_tvalid, s_tdata, s_tlast
  );

  modport slave (
    input  acc_ap_start, m_tvalid, m_tdata, m_tlast, s_tready,
    output acc_ap_idle, m_tready, s_tvalid, s_tdata, s_tlast
  );

endinterface
`default_nettype wire

// File: rtl/acc_stream_dma_pf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pf_fifo
// Purpose  : Small synchronous FIFO used to prefetch input words ahead of
//            the accelerator stream. Head word is presented combinationally.
// Ports    : clk, rst        clock, asynchronous active-high reset
//            push/push_data  write side
//            pop             consume head word
//            head            current head word
//            count           occupancy (0..DEPTH)
//            empty           occupancy is zero
// Revision : 1.0 - initial release
// ============================================================================
module pf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  // A push into a full FIFO is only harmless if the head leaves this cycle.
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/acc_stream_dma.sv
`default_nettype none
// ============================================================================
// Module   : acc_stream_dma
// Purpose  : Runs one accelerator job: launches it, prefetches input words
//            from memory into the accelerator stream, and writes the result
//            stream back to memory through a one-entry write buffer.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            cfg_*               job configuration and start pulse
//            busy/done/err       job status
//            rd_*                memory read port (data 1 cycle after grant)
//            wr_*                memory write port (held until wr_gnt)
//            acc                 accelerator start handshake and streams
// Revision : 1.0 - initial release
// ============================================================================
module acc_stream_dma
  import acc_dma_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 8,
  parameter int PF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_mode,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [LEN_W-1:0]  cfg_src_len,
  input  logic [ADDR_W-1:0] cfg_dst_addr,
  input  logic [LEN_W-1:0]  cfg_dst_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_gnt,
  acc_stream_dma_if.master  acc
);

  localparam int CW = $clog2(PF_DEPTH) + 1;
  localparam int SW = CW + 1;

  state_t            state;
  logic [2:0]        ap_start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  src_len;
  logic [LEN_W-1:0]  dst_len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  sent;
  logic [LEN_W-1:0]  received;
  logic [CW-1:0]     outstanding;
  logic              last_seen;

  logic [DATA_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fetch_active;
  logic              rx_active;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic              s_fire;

  assign fetch_active = (state == LAUNCH) || (state == STREAM);
  assign rx_active    = (state == STREAM) || (state == DRAIN);

  // Reads in flight count against FIFO space, so a granted read always
  // finds room when its data returns.
  assign rd_req  = fetch_active && (issued < src_len) &&
                   (({1'b0, fifo_count} + {1'b0, outstanding}) < SW'(PF_DEPTH));
  assign rd_addr = src_addr + ADDR_W'({issued, 2'b00});
  assign rd_fire = rd_req && rd_gnt;
  // Data for reads issued before a reset is ignored.
  assign push    = rd_valid && fetch_active && (outstanding != '0);

  // Sending waits for the accelerator to have left idle.
  assign acc.m_tvalid     = (state == STREAM) && !fifo_empty;
  assign acc.m_tdata      = acc.m_tvalid ? fifo_head : '0;
  assign acc.m_tlast      = acc.m_tvalid && (sent == (src_len - 1'b1));
  assign acc.acc_ap_start = ap_start;
  assign pop              = acc.m_tvalid && acc.m_tready;

  assign acc.s_tready = rx_active && (!wr_req || wr_gnt);
  assign s_fire       = acc.s_tvalid && acc.s_tready;

  pf_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (PF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ap_start    <= '0;
      src_addr    <= '0;
      dst_addr    <= '0;
      src_len     <= '0;
      dst_len     <= '0;
      issued      <= '0;
      sent        <= '0;
      received    <= '0;
      outstanding <= '0;
      last_seen   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      done <= 1'b0;

      if (rd_fire) issued <= issued + 1'b1;
      case ({rd_fire, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (pop) sent <= sent + 1'b1;

      // Write buffer: a granted entry empties unless refilled below.
      if (wr_req && wr_gnt) wr_req <= 1'b0;
      if (s_fire) begin
        if (acc.s_tlast) last_seen <= 1'b1;
        if (received != dst_len) begin
          wr_req   <= 1'b1;
          wr_addr  <= dst_addr + ADDR_W'({received, 2'b00});
          wr_data  <= acc.s_tdata;
          received <= received + 1'b1;
        end else begin
          // Result buffer is full: consume the word so the accelerator
          // can finish, and flag the overflow.
          err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (mode_is_valid(cfg_mode) && (cfg_src_len != '0)) begin
              src_addr  <= cfg_src_addr;
              dst_addr  <= cfg_dst_addr;
              src_len   <= cfg_src_len;
              dst_len   <= cfg_dst_len;
              ap_start  <= cfg_mode;
              issued    <= '0;
              sent      <= '0;
              received  <= '0;
              last_seen <= 1'b0;
              err       <= 1'b0;
              busy      <= 1'b1;
              state     <= LAUNCH;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (!acc.acc_ap_idle) begin
            ap_start <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (pop && acc.m_tlast) state <= DRAIN;
        end
        DRAIN: begin
          if (last_seen && !wr_req) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_stream_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_stream_dma
// Purpose  : Self-checking bench for acc_stream_dma with a memory model, an
//            accelerator model (FIR +1, matmul +0x100, ascending sort) and a
//            scoreboard of expected memory writes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acc_stream_dma;
  import acc_dma_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 8;
  localparam int PF_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cfg_start;
  logic [2:0]        cfg_mode;
  logic [ADDR_W-1:0] cfg_src_addr;
  logic [LEN_W-1:0]  cfg_src_len;
  logic [ADDR_W-1:0] cfg_dst_addr;
  logic [LEN_W-1:0]  cfg_dst_len;
  logic              busy, done, err;
  logic              rd_req, rd_gnt, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              wr_req, wr_gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  acc_stream_dma_if acc ();

  acc_stream_dma #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .PF_DEPTH (PF_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_mode     (cfg_mode),
    .cfg_src_addr (cfg_src_addr),
    .cfg_src_len  (cfg_src_len),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_dst_len  (cfg_dst_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .acc          (acc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- environment state ----------------
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] src_mem [256];
  logic [31:0] src_base = '0;
  int          cur_len = 0;
  int          m_idx, tlast_cnt, s_cnt, done_cnt, wr_cnt;
  bit          rdy_pat = 1'b0;
  bit          gnt_alt = 1'b0;
  int          cyc = 0;

  // Memory read port and stream-ready pattern generator.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_valid <= rd_req && rd_gnt;
    rd_data  <= src_mem[8'((rd_addr - src_base) >> 2)];
    rd_gnt   <= gnt_alt ? ~rd_gnt : 1'b1;
    acc.m_tready <= rdy_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Accelerator model: collect the whole input job, then emit results.
  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic [31:0] tmp;
  logic [2:0]  acc_mode = '0;
  always @(posedge clk) begin
    if (rst) begin
      in_q.delete();
      out_q.delete();
      acc.acc_ap_idle <= 1'b1;
      acc.s_tvalid    <= 1'b0;
      acc.s_tdata     <= '0;
      acc.s_tlast     <= 1'b0;
    end else begin
      if (acc.acc_ap_idle && acc.acc_ap_start != 3'b000) begin
        acc.acc_ap_idle <= 1'b0;
        acc_mode        <= acc.acc_ap_start;
        in_q.delete();
      end
      if (acc.m_tvalid && acc.m_tready) begin
        in_q.push_back(acc.m_tdata);
        if (acc.m_tlast) begin
          out_q.delete();
          foreach (in_q[i]) out_q.push_back(in_q[i]);
          if (acc_mode == MODE_SORT) begin
            for (int i = 0; i < out_q.size(); i++)
              for (int j = 0; j + 1 < out_q.size() - i; j++)
                if (out_q[j] > out_q[j+1]) begin
                  tmp = out_q[j]; out_q[j] = out_q[j+1]; out_q[j+1] = tmp;
                end
          end else begin
            for (int i = 0; i < out_q.size(); i++)
              out_q[i] = out_q[i] + ((acc_mode == MODE_MATMUL) ? 32'h100 : 32'h1);
          end
        end
      end
      if (!acc.s_tvalid || acc.s_tready) begin
        if (acc.s_tvalid && acc.s_tlast) acc.acc_ap_idle <= 1'b1;
        if (out_q.size() > 0) begin
          tmp = out_q.pop_front();
          acc.s_tvalid <= 1'b1;
          acc.s_tdata  <= tmp;
          acc.s_tlast  <= (out_q.size() == 0);
        end else begin
          acc.s_tvalid <= 1'b0;
          acc.s_tlast  <= 1'b0;
        end
      end
    end
  end

  // Output monitor and scoreboard; samples on the falling edge.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("m_stall_valid", acc.m_tvalid, 1);
        chk("m_stall_data", acc.m_tdata, prev_data);
        chk("m_stall_last", acc.m_tlast, prev_last);
      end
      prev_stall = acc.m_tvalid && !acc.m_tready;
      prev_data  = acc.m_tdata;
      prev_last  = acc.m_tlast;
      if (acc.m_tvalid && acc.m_tready) begin
        chk("m_data_order", acc.m_tdata, src_mem[m_idx]);
        chk("m_tlast", acc.m_tlast, (m_idx == cur_len - 1));
        if (acc.m_tlast) tlast_cnt++;
        m_idx++;
      end
      if (acc.s_tvalid && acc.s_tready) s_cnt++;
      if (wr_req && wr_gnt) begin
        wr_cnt++;
        chk("wr_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (done) done_cnt++;
      if (busy) chk("fifo_count_bound", dut.u_fifo.count <= PF_DEPTH, 1);
    end
  end

  // ---------------- directed-step helpers ----------------
  task automatic pulse_start(input logic [2:0] mode, input logic [31:0] sa, input int slen,
                             input logic [31:0] da, input int dlen);
    @(posedge clk); #1;
    cfg_mode     = mode;
    cfg_src_addr = sa;
    cfg_src_len  = LEN_W'(slen);
    cfg_dst_addr = da;
    cfg_dst_len  = LEN_W'(dlen);
    cfg_start    = 1'b1;
    @(posedge clk); #1;
    cfg_start    = 1'b0;
  endtask

  task automatic begin_job(input logic [2:0] mode, input logic [31:0] sa, input int slen,
                           input logic [31:0] da, input int dlen);
    src_base  = sa;
    cur_len   = slen;
    m_idx     = 0;
    tlast_cnt = 0;
    s_cnt     = 0;
    done_cnt  = 0;
    wr_cnt    = 0;
    pulse_start(mode, sa, slen, da, dlen);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    bit pb   = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({tag, "_busy_low_at_done"}, busy, 0);
        chk({tag, "_busy_before_done"}, pb, 1);
      end
      pb = busy;
    end
    chk({tag, "_done_seen"}, seen, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic post_checks(input string tag, input int writes, input int sent_n, input logic e_err);
    chk({tag, "_writes"}, wr_cnt, writes);
    chk({tag, "_words_sent"}, m_idx, sent_n);
    chk({tag, "_tlast_count"}, tlast_cnt, 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  task automatic invalid_start(input string tag, input logic [2:0] mode, input int slen);
    done_cnt = 0;
    pulse_start(mode, 32'h5000, slen, 32'h6000, 8);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_ap_start"}, acc.acc_ap_start, 0);
    @(negedge clk);
    chk({tag, "_done_dropped"}, done, 0);
    chk({tag, "_rd_req_later"}, rd_req, 0);
    chk({tag, "_ap_start_later"}, acc.acc_ap_start, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_ap_start"}, acc.acc_ap_start, 0);
    chk({tag, "_m_tvalid"}, acc.m_tvalid, 0);
    chk({tag, "_m_tdata"}, acc.m_tdata, 0);
    chk({tag, "_m_tlast"}, acc.m_tlast, 0);
    chk({tag, "_s_tready"}, acc.s_tready, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst          = 1'b1;
    cfg_start    = 1'b0;
    cfg_mode     = '0;
    cfg_src_addr = '0;
    cfg_src_len  = '0;
    cfg_dst_addr = '0;
    cfg_dst_len  = '0;
    wr_gnt       = 1'b1;
    rd_gnt       = 1'b1;
    rd_valid     = 1'b0;
    foreach (src_mem[i]) src_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // FIR, 64 words, echo +1.
    for (int i = 0; i < 64; i++) begin
      src_mem[i] = $urandom;
      exp_q.push_back('{32'h2000 + 32'(4 * i), src_mem[i] + 32'd1});
    end
    begin_job(MODE_FIR, 32'h1000, 64, 32'h2000, 64);
    wait_done("fir", 2000);
    post_checks("fir", 64, 64, 1'b0);

    // Sort, descending input 10..1 comes back ascending.
    for (int i = 0; i < 10; i++) begin
      src_mem[i] = 32'(10 - i);
      exp_q.push_back('{32'h4000 + 32'(4 * i), 32'(i + 1)});
    end
    begin_job(MODE_SORT, 32'h3000, 10, 32'h4000, 10);
    wait_done("sort", 1000);
    post_checks("sort", 10, 10, 1'b0);

    // Non-one-hot mode.
    invalid_start("bad_mode", 3'b011, 5);

    // Backpressure on both the stream and the read grant.
    rdy_pat = 1'b1;
    gnt_alt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      src_mem[i] = $urandom;
      exp_q.push_back('{32'h8000 + 32'(4 * i), src_mem[i] + 32'd1});
    end
    begin_job(MODE_FIR, 32'h7000, 20, 32'h8000, 20);
    wait_done("bp", 2000);
    post_checks("bp", 20, 20, 1'b0);
    rdy_pat = 1'b0;
    gnt_alt = 1'b0;

    // Zero length with a valid mode.
    invalid_start("zero_len", MODE_FIR, 0);

    // Overflow: 16 results into an 8-word buffer.
    for (int i = 0; i < 16; i++) begin
      src_mem[i] = $urandom;
      if (i < 8) exp_q.push_back('{32'hA000 + 32'(4 * i), src_mem[i] + 32'h100});
    end
    begin_job(MODE_MATMUL, 32'h9000, 16, 32'hA000, 8);
    wait_done("ovf", 1000);
    post_checks("ovf", 8, 16, 1'b1);
    chk("ovf_results_accepted", s_cnt, 16);

    // Asynchronous reset in the middle of the input stream.
    for (int i = 0; i < 32; i++) begin
      src_mem[i] = $urandom;
      exp_q.push_back('{32'hC000 + 32'(4 * i), src_mem[i] + 32'd1});
    end
    begin_job(MODE_FIR, 32'hB000, 32, 32'hC000, 32);
    begin
      bit reached = 1'b0;
      for (int c = 0; c < 500 && !reached; c++) begin
        @(negedge clk);
        if (m_idx >= 5) reached = 1'b1;
      end
      chk("rst_mid_reached_5_words", reached, 1);
    end
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_mid");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      src_mem[i] = $urandom;
      exp_q.push_back('{32'hE000 + 32'(4 * i), src_mem[i] + 32'd1});
    end
    begin_job(MODE_FIR, 32'hD000, 24, 32'hE000, 24);
    wait_done("after_rst", 1000);
    post_checks("after_rst", 24, 24, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
